// File: rtl/stack_engine.sv
// Registered LIFO stack engine with PUSH/POP/REPL and a sticky fault flag.
// DUP and SWAP are compiled in only when STACK_ENGINE_DUPSWAP_EN is defined.
module stack_engine #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_word,
  output logic [WIDTH-1:0] top_word,
  output logic [WIDTH-1:0] second_word,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_REPL = 3'b011;
  localparam logic [2:0] OP_DUP  = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_err;

  logic [WIDTH-1:0] w_stack_d [DEPTH];
  logic [CW-1:0]    w_count_d;
  logic             w_err_d;
  logic             w_full;
  logic             w_empty;
  logic             w_two;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_do_repl;
  logic             w_do_swap;
  logic             w_fault;
  logic [WIDTH-1:0] w_push_data;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_two   = (r_count >= CNT_TWO);

  // Decode the op into one action; an illegal op raises a fault and changes nothing else.
  always_comb begin
    w_do_push   = 1'b0;
    w_do_pop    = 1'b0;
    w_do_repl   = 1'b0;
    w_do_swap   = 1'b0;
    w_fault     = 1'b0;
    w_push_data = in_word;
    if (valid) begin
      case (op)
        OP_PUSH: if (w_full) w_fault = 1'b1; else w_do_push = 1'b1;
        OP_POP:  if (w_empty) w_fault = 1'b1; else w_do_pop = 1'b1;
        OP_REPL: if (!w_two) w_fault = 1'b1; else w_do_repl = 1'b1;
`ifdef STACK_ENGINE_DUPSWAP_EN
        OP_DUP: begin
          w_push_data = r_stack[0];
          if (w_full || w_empty) w_fault = 1'b1;
          else w_do_push = 1'b1;
        end
        OP_SWAP: if (!w_two) w_fault = 1'b1; else w_do_swap = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    w_stack_d = r_stack;
    w_count_d = r_count;
    w_err_d   = r_err | w_fault;
    if (w_do_push) begin
      for (int unsigned i = 1; i < DEPTH; i++) w_stack_d[i] = r_stack[i-1];
      w_stack_d[0] = w_push_data;
      w_count_d    = r_count + CNT_ONE;
    end else if (w_do_pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) w_stack_d[i] = r_stack[i+1];
      w_stack_d[DEPTH-1] = '0;
      w_count_d          = r_count - CNT_ONE;
    end else if (w_do_repl) begin
      w_stack_d[0] = in_word;
      for (int unsigned i = 1; i < DEPTH - 1; i++) w_stack_d[i] = r_stack[i+1];
      w_stack_d[DEPTH-1] = '0;
      w_count_d          = r_count - CNT_ONE;
    end else if (w_do_swap) begin
      w_stack_d[0] = r_stack[1];
      w_stack_d[1] = r_stack[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stack[i] <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stack[i] <= w_stack_d[i];
      r_count <= w_count_d;
      r_err   <= w_err_d;
    end
  end

  assign top_word    = r_stack[0];
  assign second_word = r_stack[1];
  assign count       = r_count;
  assign empty       = w_empty;
  assign full        = w_full;
  assign err         = r_err;

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine (WIDTH=4, DEPTH=8); DUP/SWAP expectations follow
// STACK_ENGINE_DUPSWAP_EN.
module tb_stack_engine;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [2:0] op;
  logic [3:0] in_word;
  logic [3:0] top_word;
  logic [3:0] second_word;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid       (valid),
    .op          (op),
    .in_word     (in_word),
    .top_word    (top_word),
    .second_word (second_word),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [2:0] op;
    logic [3:0] in_w;
    logic [3:0] top;
    logic [3:0] sec;
    logic [3:0] cnt;
    logic       emp;
    logic       ful;
    logic       er;
  } vec_t;

  vec_t tbl[$];

  task automatic step(input logic r, input logic v, input logic [2:0] o, input logic [3:0] d);
    rst     = r;
    valid   = v;
    op      = o;
    in_word = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] et, input logic [3:0] es,
                       input logic [3:0] ec, input logic ee, input logic ef, input logic er);
    logic [14:0] got, exp;
    got = {top_word, second_word, count, empty, full, err};
    exp = {et, es, ec, ee, ef, er};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got top=%0d sec=%0d cnt=%0d empty=%b full=%b err=%b, need top=%0d sec=%0d cnt=%0d empty=%b full=%b err=%b",
                  name, top_word, second_word, count, empty, full, err, et, es, ec, ee, ef, er);
  endtask

  initial begin
    // rst valid op in | top sec cnt empty full err
    tbl.push_back('{1'b1, 1'b0, 3'd0, 4'd0,  4'd0,  4'd0, 4'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 4'd3,  4'd3,  4'd0, 4'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 4'd5,  4'd5,  4'd3, 4'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd0, 4'd9,  4'd5,  4'd3, 4'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd1, 4'd9,  4'd5,  4'd3, 4'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd6, 4'd9,  4'd5,  4'd3, 4'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 4'd0,  4'd3,  4'd0, 4'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 4'd0,  4'd0,  4'd0, 4'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 4'd0,  4'd0,  4'd0, 4'd0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 4'd4,  4'd4,  4'd0, 4'd1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 4'd0,  4'd0,  4'd0, 4'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 4'd2,  4'd2,  4'd0, 4'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 4'd6,  4'd6,  4'd2, 4'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 4'd7,  4'd7,  4'd6, 4'd3, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd3, 4'd13, 4'd13, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd3, 4'd1,  4'd1,  4'd0, 4'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd3, 4'd5,  4'd1,  4'd0, 4'd1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 4'd0,  4'd0,  4'd0, 4'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 4'd1,  4'd1,  4'd0, 4'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 4'd2,  4'd2,  4'd1, 4'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 4'd3,  4'd3,  4'd2, 4'd3, 1'b0, 1'b0, 1'b0});
    // reset wins over a simultaneous PUSH 15, then the next edge accepts an op
    tbl.push_back('{1'b1, 1'b1, 3'd1, 4'd15, 4'd0,  4'd0, 4'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 4'd15, 4'd15, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd7, 4'd8,  4'd15, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0});

    rst = 1'b1; valid = 1'b0; op = 3'd0; in_word = 4'd0;
    #2;

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].valid, tbl[i].op, tbl[i].in_w);
      check($sformatf("vec%0d", i), tbl[i].top, tbl[i].sec, tbl[i].cnt,
            tbl[i].emp, tbl[i].ful, tbl[i].er);
    end

    // Fill to DEPTH, overflow, then pop with err still latched
    step(1'b1, 1'b0, 3'd0, 4'd0);
    for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, 3'd1, 4'(k));
    check("fill8", 4'd8, 4'd7, 4'd8, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3'd1, 4'd9);
    check("push_full", 4'd8, 4'd7, 4'd8, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 3'd2, 4'd0);
    check("pop_after_full", 4'd7, 4'd6, 4'd7, 1'b0, 1'b0, 1'b1);

    // DUP/SWAP: real ops when compiled in, silent NOPs otherwise
    step(1'b1, 1'b0, 3'd0, 4'd0);
    step(1'b0, 1'b1, 3'd5, 4'd0);
`ifdef STACK_ENGINE_DUPSWAP_EN
    check("swap_empty", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
`else
    check("swap_empty", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
`endif
    step(1'b1, 1'b0, 3'd0, 4'd0);
    step(1'b0, 1'b1, 3'd1, 4'd1);
    step(1'b0, 1'b1, 3'd1, 4'd9);
    step(1'b0, 1'b1, 3'd5, 4'd0);
`ifdef STACK_ENGINE_DUPSWAP_EN
    check("swap", 4'd1, 4'd9, 4'd2, 1'b0, 1'b0, 1'b0);
`else
    check("swap", 4'd9, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
`endif
    step(1'b0, 1'b1, 3'd4, 4'd0);
`ifdef STACK_ENGINE_DUPSWAP_EN
    check("dup", 4'd1, 4'd1, 4'd3, 1'b0, 1'b0, 1'b0);
`else
    check("dup", 4'd9, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_engine.md
STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 4, bit width of one stack word.
REQ-002 SHALL have parameter DEPTH, default 8, maximum number of stored words (DEPTH >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port valid  input  1  qualifies op; op ignored when low.
REQ-006 SHALL have port op  input  3  operation code (REQ-012).
REQ-007 SHALL have port in_word  input  WIDTH  data for PUSH/REPL.
REQ-008 SHALL have port top_word  output  WIDTH  entry 0 (top of stack).
REQ-009 SHALL have port second_word  output  WIDTH  entry 1.
REQ-010 SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-011 SHALL have ports empty, full, err  output  1 each  count==0, count==DEPTH, sticky fault flag.

Function
REQ-012 SHALL decode op as: 000 NOP; 001 PUSH; 010 POP; 011 REPL (drop top two, push in_word); 100 DUP (push copy of top); 101 SWAP (exchange entries 0 and 1); 110/111 reserved, treated as NOP without setting err.
REQ-013 SHALL execute at most one op per cycle, when valid=1; result visible on all outputs the cycle after the sampling edge (1-cycle latency, registered outputs).
REQ-014 SHALL on PUSH shift entries down one position and load in_word into entry 0; count+1.
REQ-015 SHALL on POP shift entries up one position, load zero into entry DEPTH-1; count-1.
REQ-016 SHALL on REPL load in_word into entry 0, shift entries 2..DEPTH-1 up into 1..DEPTH-2, zero the vacated bottom entry; count-1.
REQ-017 SHALL on DUP behave as PUSH with in_word replaced by current entry 0.
REQ-018 SHALL on SWAP exchange entries 0 and 1; count unchanged.
REQ-019 SHALL hold entries at or below count as zero, so top_word=0 when count==0 and second_word=0 when count<2.
REQ-020 SHALL treat PUSH/DUP at full, POP at empty, REPL/SWAP with count<2, DUP at empty as faults: stack and count unchanged, err set to 1.
REQ-021 SHALL keep err at 1 until reset; later legal ops execute normally.
REQ-022 SHALL update empty/full combinationally from registered count only.

Reset
REQ-023 SHALL on rst=1 at a clock edge clear all entries to zero, count=0, empty=1, full=0, err=0, top_word=0, second_word=0.
REQ-024 SHALL give rst priority over any simultaneous valid op; the op is discarded.
REQ-025 SHALL accept a new op on the first edge after rst deasserts.

Configuration
REQ-026 SHALL compile DUP and SWAP support only when macro STACK_ENGINE_DUPSWAP_EN is defined.
REQ-027 SHALL, without STACK_ENGINE_DUPSWAP_EN, treat op 100 and 101 as reserved NOPs (no state change, no err); all other behaviour identical.

Verification (WIDTH=4, DEPTH=8)
REQ-028 SHALL cover: rst, PUSH 3, PUSH 5 -> top_word=5, second_word=3, count=2, empty=0, err=0.
REQ-029 SHALL cover: 8 PUSHes 1..8 then PUSH 9 -> full=1, count=8, top_word=8, err=1; then POP -> top_word=7, count=7, err still 1.
REQ-030 SHALL cover: after rst, POP -> count=0, top_word=0, err=1; then PUSH 4 -> top_word=4, count=1.
REQ-031 SHALL cover: PUSH 2, PUSH 6, PUSH 7, REPL in_word=13 -> top_word=13, second_word=2, count=2.
REQ-032 SHALL cover (macro defined): PUSH 1, PUSH 9, SWAP -> top_word=1, second_word=9; DUP -> top_word=1, second_word=1, count=3; macro undefined -> same ops leave top_word=9, count=2, err=0.
REQ-033 SHALL cover: rst asserted together with valid PUSH 15 at count=3 -> count=0, top_word=0, err=0 next cycle.
